// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: states, instruction classes,
// opcode/funct values, ALU op codes and datapath select codes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch, StDecode, StExec, StMem, StWb, StTrap
    } state_e;

    typedef enum logic [3:0] {
        ClsR, ClsJr, ClsIalu, ClsLw, ClsSw, ClsBeq, ClsJ, ClsJal, ClsIll
    } cls_e;

    localparam logic [1:0] OPT_R    = 2'd0;
    localparam logic [1:0] OPT_I    = 2'd1;
    localparam logic [1:0] OPT_J    = 2'd2;
    localparam logic [1:0] OPT_ZERO = 2'd3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_LUI  = 4'd5;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_RS     = 2'd3;

    localparam logic [1:0] WSEL_RT = 2'd0;
    localparam logic [1:0] WSEL_RD = 2'd1;
    localparam logic [1:0] WSEL_RA = 2'd2;

    localparam logic [1:0] DSEL_ALU = 2'd0;
    localparam logic [1:0] DSEL_MEM = 2'd1;
    localparam logic [1:0] DSEL_PC4 = 2'd2;

endpackage

// File: rtl/mc_ctrl_if.sv
// Shared memory port between the control sequencer (master) and the memory (slave).
interface mc_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_ifetch;
    logic mem_ack;

    modport master (output mem_req, output mem_we, output mem_ifetch, input mem_ack);
    modport slave  (input mem_req, input mem_we, input mem_ifetch, output mem_ack);
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decode: opcode/funct -> class, ALU op, operand type, legal flag.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output cls_e       cls,
    output logic [3:0] alu_op,
    output logic [1:0] optype,
    output logic       legal
);

    always_comb begin
        cls    = ClsIll;
        alu_op = ALU_ADD;
        optype = OPT_ZERO;
        case (opcode)
            OP_RTYPE: begin
                optype = OPT_R;
                case (funct)
                    FN_ADDU: begin cls = ClsR; alu_op = ALU_ADD; end
                    FN_SUBU: begin cls = ClsR; alu_op = ALU_SUB; end
                    FN_AND:  begin cls = ClsR; alu_op = ALU_AND; end
                    FN_OR:   begin cls = ClsR; alu_op = ALU_OR;  end
                    FN_SLT:  begin cls = ClsR; alu_op = ALU_SLT; end
                    FN_JR:   cls = ClsJr;
                    default: cls = ClsIll;
                endcase
            end
            OP_ADDIU: begin cls = ClsIalu; optype = OPT_I; alu_op = ALU_ADD; end
            OP_ORI:   begin cls = ClsIalu; optype = OPT_I; alu_op = ALU_OR;  end
            OP_LUI:   begin cls = ClsIalu; optype = OPT_I; alu_op = ALU_LUI; end
            OP_LW:    begin cls = ClsLw;   optype = OPT_I; alu_op = ALU_ADD; end
            OP_SW:    begin cls = ClsSw;   optype = OPT_I; alu_op = ALU_ADD; end
            OP_BEQ:   begin cls = ClsBeq;  optype = OPT_R; alu_op = ALU_SUB; end
            OP_J:     begin cls = ClsJ;    optype = OPT_J; end
            OP_JAL:   begin cls = ClsJal;  optype = OPT_J; end
            default:  cls = ClsIll;
        endcase
        legal = (cls != ClsIll);
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: FETCH->DECODE->EXEC->MEM->WB with memory wait timeout.
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap on unknown instructions instead of retiring them as NOPs.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W  = 4,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               alu_zero,
    mc_ctrl_if.master          mem,
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         pc_src,
    output logic [1:0]         optype,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               rf_we,
    output logic [1:0]         rf_wsel,
    output logic [1:0]         rf_dsel,
    output logic               retire,
    output logic               err
);

    localparam int unsigned CntW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

    state_e            state_q, state_d;
    logic [5:0]        op_q, fn_q;
    logic              pend_q, pend_d;
    logic              err_q, err_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              req, ack;

    cls_e              cls;
    logic [3:0]        dec_alu_op;
    logic [1:0]        dec_optype;
    logic              legal;

    // DECODE sees the freshly loaded IR; later states use the fields latched in DECODE.
    mc_ctrl_decode u_decode (
        .opcode (state_q == StDecode ? opcode : op_q),
        .funct  (state_q == StDecode ? funct  : fn_q),
        .cls    (cls),
        .alu_op (dec_alu_op),
        .optype (dec_optype),
        .legal  (legal)
    );

    assign ack            = mem.mem_ack;
    assign mem.mem_req    = req;
    assign err            = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            op_q    <= '0;
            fn_q    <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            if (state_q == StDecode) begin
                op_q <= opcode;
                fn_q <= funct;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        pend_d         = pend_q;
        err_d          = err_q;
        cnt_d          = '0;
        req            = 1'b0;
        mem.mem_we     = 1'b0;
        mem.mem_ifetch = 1'b0;
        ir_we          = 1'b0;
        pc_we          = 1'b0;
        pc_src         = PC_PLUS4;
        optype         = OPT_R;
        alu_op         = '0;
        rf_we          = 1'b0;
        rf_wsel        = WSEL_RT;
        rf_dsel        = DSEL_ALU;
        retire         = 1'b0;

        case (state_q)
            StFetch: begin
                // Gating with reset keeps the port quiet while reset is held.
                req            = (run | pend_q) & ~reset;
                mem.mem_ifetch = req;
                if (req) begin
                    if (ack) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        pend_d  = 1'b0;
                        state_d = StDecode;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end
            StDecode: begin
                if (!legal) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    err_d   = 1'b1;
                    state_d = StTrap;
`else
                    retire  = 1'b1;
                    state_d = StFetch;
`endif
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                optype = dec_optype;
                alu_op = ALUOP_W'(dec_alu_op);
                case (cls)
                    ClsR, ClsIalu: state_d = StWb;
                    ClsLw, ClsSw:  state_d = StMem;
                    ClsJr: begin
                        pc_we = 1'b1; pc_src = PC_RS; retire = 1'b1; state_d = StFetch;
                    end
                    ClsBeq: begin
                        pc_we = alu_zero; pc_src = PC_BRANCH; retire = 1'b1; state_d = StFetch;
                    end
                    ClsJ: begin
                        pc_we = 1'b1; pc_src = PC_JUMP; retire = 1'b1; state_d = StFetch;
                    end
                    ClsJal: begin
                        pc_we   = 1'b1; pc_src  = PC_JUMP; retire = 1'b1; state_d = StFetch;
                        rf_we   = 1'b1; rf_wsel = WSEL_RA; rf_dsel = DSEL_PC4;
                    end
                    default: state_d = StFetch;
                endcase
            end
            StMem: begin
                optype     = dec_optype;
                alu_op     = ALUOP_W'(dec_alu_op);
                req        = 1'b1;
                mem.mem_we = (cls == ClsSw);
                if (ack) begin
                    if (cls == ClsSw) begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                optype  = dec_optype;
                alu_op  = ALUOP_W'(dec_alu_op);
                rf_we   = 1'b1;
                retire  = 1'b1;
                state_d = StFetch;
                if (cls == ClsR)  rf_wsel = WSEL_RD;
                if (cls == ClsLw) rf_dsel = DSEL_MEM;
            end
            StTrap: ;
            default: state_d = StFetch;
        endcase

        if (req && !ack) begin
            if (WAIT_MAX != 0 && cnt_q == CntW'(WAIT_MAX - 1)) begin
                err_d   = 1'b1;
                pend_d  = 1'b0;
                state_d = StFetch;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomised self-checking bench for mc_ctrl_fsm against an instruction-level reference model.
module tb_mc_ctrl_fsm;
    import mc_ctrl_pkg::*;

    localparam int unsigned WaitMax = 4;

    typedef struct packed {
        logic       req, we, ifetch, ir_we, pc_we;
        logic [1:0] pc_src, optype;
        logic [3:0] alu_op;
        logic       rf_we;
        logic [1:0] wsel, dsel;
        logic       retire, err;
    } obs_t;

    typedef enum {KR, KJr, KIalu, KLw, KSw, KBeq, KJ, KJal, KIll} kind_e;

    logic       clk = 1'b0;
    logic       reset, run, alu_zero;
    logic [5:0] opcode, funct;
    logic       ir_we, pc_we, rf_we, retire, err;
    logic [1:0] pc_src, optype, rf_wsel, rf_dsel;
    logic [3:0] alu_op;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic        err_m   = 1'b0;

    mc_ctrl_if mem_bus ();

    mc_ctrl_fsm #(.ALUOP_W(4), .WAIT_MAX(WaitMax)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem(mem_bus), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .optype(optype), .alu_op(alu_op), .rf_we(rf_we), .rf_wsel(rf_wsel), .rf_dsel(rf_dsel),
        .retire(retire), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.req = mem_bus.mem_req; o.we = mem_bus.mem_we; o.ifetch = mem_bus.mem_ifetch;
        o.ir_we = ir_we; o.pc_we = pc_we; o.pc_src = pc_src; o.optype = optype;
        o.alu_op = alu_op; o.rf_we = rf_we; o.wsel = rf_wsel; o.dsel = rf_dsel;
        o.retire = retire; o.err = err;
        return o;
    endfunction

    function automatic obs_t blank();
        obs_t e = '0;
        e.err = err_m;
        return e;
    endfunction

    // Called just after a rising edge with this cycle's inputs already applied.
    task automatic step(input obs_t e, input string tag);
        #1;
        check(tag, 32'(sample()), 32'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        obs_t z = '0;
        reset = 1'b1;
        run   = 1'b1;
        #1;
        check("reset", 32'(sample()), 32'(z));
        @(posedge clk);
        #1;
        reset = 1'b0;
        err_m = 1'b0;
    endtask

    task automatic ref_decode(input logic [5:0] op, input logic [5:0] fn, output kind_e k,
                              output logic [3:0] a, output logic [1:0] ot);
        k = KIll; a = ALU_ADD; ot = OPT_R;
        case (op)
            6'h00: case (fn)
                6'h21: begin k = KR; a = ALU_ADD; end
                6'h23: begin k = KR; a = ALU_SUB; end
                6'h24: begin k = KR; a = ALU_AND; end
                6'h25: begin k = KR; a = ALU_OR;  end
                6'h2A: begin k = KR; a = ALU_SLT; end
                6'h08: k = KJr;
                default: k = KIll;
            endcase
            6'h09: begin k = KIalu; a = ALU_ADD; ot = OPT_I; end
            6'h0D: begin k = KIalu; a = ALU_OR;  ot = OPT_I; end
            6'h0F: begin k = KIalu; a = ALU_LUI; ot = OPT_I; end
            6'h23: begin k = KLw;   ot = OPT_I; end
            6'h2B: begin k = KSw;   ot = OPT_I; end
            6'h04: begin k = KBeq;  a = ALU_SUB; end
            6'h02: begin k = KJ;    ot = OPT_J; end
            6'h03: begin k = KJal;  ot = OPT_J; end
            default: k = KIll;
        endcase
    endtask

    // fdel/mdel: cycles without ack before the ack; mdel >= WaitMax never acks.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fdel,
                             input int mdel, input logic z, input int rst_at);
        kind_e k; logic [3:0] a; logic [1:0] ot; obs_t e; logic done;
        ref_decode(op, fn, k, a, ot);
        for (int i = 0; i <= fdel; i++) begin
            run = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            mem_bus.mem_ack = (i == fdel);
            opcode = 6'($urandom); funct = 6'($urandom);
            e = blank(); e.req = 1'b1; e.ifetch = 1'b1;
            e.ir_we = (i == fdel); e.pc_we = (i == fdel);
            step(e, "fetch");
        end
        run = 1'($urandom); opcode = op; funct = fn;
        mem_bus.mem_ack = 1'($urandom); alu_zero = 1'($urandom);
        e = blank();
        if (k == KIll) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            step(e, "decode_ill");
            err_m = 1'b1;
            for (int i = 0; i < 3; i++) begin
                run = 1'b1; mem_bus.mem_ack = 1'($urandom);
                e = blank(); step(e, "trap");
            end
            do_reset();
`else
            e.retire = 1'b1;
            step(e, "decode_nop");
`endif
            return;
        end
        step(e, "decode");
        opcode = 6'($urandom); funct = 6'($urandom); alu_zero = z;
        mem_bus.mem_ack = 1'($urandom); run = 1'($urandom);
        e = blank(); e.optype = ot; e.alu_op = a;
        case (k)
            KJr:  begin e.pc_we = 1'b1; e.pc_src = 2'd3; e.retire = 1'b1; end
            KBeq: begin e.pc_we = z;    e.pc_src = 2'd1; e.retire = 1'b1; end
            KJ:   begin e.pc_we = 1'b1; e.pc_src = 2'd2; e.retire = 1'b1; end
            KJal: begin
                e.pc_we = 1'b1; e.pc_src = 2'd2; e.retire = 1'b1;
                e.rf_we = 1'b1; e.wsel = 2'd2; e.dsel = 2'd2;
            end
            default: ;
        endcase
        step(e, "exec");
        if (e.retire) return;
        if (k == KLw || k == KSw) begin
            done = 1'b0;
            for (int i = 0; i < int'(WaitMax) && !done; i++) begin
                if (i == rst_at) begin
                    do_reset();
                    return;
                end
                run = 1'($urandom); opcode = 6'($urandom);
                mem_bus.mem_ack = (i == mdel);
                e = blank(); e.optype = ot; e.alu_op = a; e.req = 1'b1; e.we = (k == KSw);
                e.retire = (i == mdel) && (k == KSw);
                step(e, "mem");
                done = (i == mdel);
            end
            if (!done) begin
                err_m = 1'b1;
                return;
            end
            if (k == KSw) return;
        end
        mem_bus.mem_ack = 1'($urandom); run = 1'($urandom); opcode = 6'($urandom);
        e = blank(); e.optype = ot; e.alu_op = a; e.rf_we = 1'b1; e.retire = 1'b1;
        e.wsel = (k == KR) ? 2'd1 : 2'd0;
        e.dsel = (k == KLw) ? 2'd1 : 2'd0;
        step(e, "wb");
    endtask

    task automatic idle(input int n);
        obs_t e;
        for (int i = 0; i < n; i++) begin
            run = 1'b0; mem_bus.mem_ack = 1'($urandom); opcode = 6'($urandom);
            e = blank();
            step(e, "idle");
        end
    endtask

    logic [5:0] ops [10] = '{6'h00, 6'h00, 6'h09, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
    logic [5:0] fns [6]  = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h08};

    initial begin
        logic [5:0] op, fn;
        int mdel;
        reset = 1'b1; run = 1'b1; alu_zero = 1'b0; opcode = '0; funct = '0;
        mem_bus.mem_ack = 1'b1;
        #2;
        check("reset_init", 32'(sample()), 32'(obs_t'('0)));
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr(6'h00, 6'h21, 0, 0, 1'b0, -1);   // addu
        run_instr(6'h23, 6'h00, 1, 3, 1'b0, -1);   // lw, late ack
        run_instr(6'h04, 6'h00, 0, 0, 1'b1, -1);   // beq taken
        run_instr(6'h04, 6'h00, 0, 0, 1'b0, -1);   // beq not taken
        run_instr(6'h03, 6'h00, 0, 0, 1'b0, -1);   // jal
        run_instr(6'h3F, 6'h00, 0, 0, 1'b0, -1);   // illegal
        run_instr(6'h23, 6'h00, 0, 99, 1'b0, -1);  // lw timeout
        run_instr(6'h2B, 6'h00, 2, 1, 1'b0, -1);   // sw after error
        run_instr(6'h23, 6'h00, 0, 99, 1'b0, 2);   // reset mid-MEM
        idle(2);

        for (int n = 0; n < 250; n++) begin
            op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 9)] : 6'($urandom);
            fn = ($urandom_range(0, 9) < 8) ? fns[$urandom_range(0, 5)] : 6'($urandom);
            mdel = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 3));
            run_instr(op, fn, int'($urandom_range(0, 3)), mdel, 1'($urandom), -1);
            idle(int'($urandom_range(0, 2)));
            if ($urandom_range(0, 39) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
